input_capture: RTL and testbench

INPUT_CAPTURE -- requirements
Module: input_capture

---
 rtl/input_capture_if.sv | 31 +++
 rtl/input_capture.sv | 123 ++++++++++++
 tb/tb_input_capture.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/input_capture_if.sv
// Processor-facing input port: raw button/switch pins in; captured switch data, valid pulse,
// debounced button level and pipeline stall out.
interface input_capture_if;
    logic       button_raw;
    logic [3:0] switches_raw;
    logic       read_req;
    logic [3:0] data_out;
    logic       data_valid;
    logic       stall;
    logic       button_level;

    modport slave (
        input  button_raw,
        input  switches_raw,
        input  read_req,
        output data_out,
        output data_valid,
        output stall,
        output button_level
    );

    modport master (
        output button_raw,
        output switches_raw,
        output read_req,
        input  data_out,
        input  data_valid,
        input  stall,
        input  button_level
    );
endinterface

// File: rtl/input_capture.sv
// Captures the switch bank on a debounced button press while the processor requests input;
// 2 sync + DEBOUNCE_CYCLES + 2 cycles press-to-data_valid, stall holds the processor meanwhile.
module input_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           reset,
    input_capture_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        CAPTURED,
        WAIT_RELEASE
    } state_t;

    logic             btn_meta_q;
    logic             btn_sync_q;
    logic [3:0]       sw_meta_q;
    logic [3:0]       sw_sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             press_q;
    state_t           state_q;
    state_t           state_d;
    logic [3:0]       data_q;
    logic [3:0]       data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            sw_meta_q  <= 4'h0;
            sw_sync_q  <= 4'h0;
        end else begin
            btn_meta_q <= bus.button_raw;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= bus.switches_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Any cycle where the synchronized button agrees with the stable level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (btn_sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.read_req) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                // Dropping read_req wins over a coincident press: the instruction is gone.
                if (!bus.read_req) begin
                    state_d = IDLE;
                end else if (press_q) begin
                    data_d  = sw_sync_q;
                    state_d = CAPTURED;
                end
            end
            CAPTURED: begin
                state_d = level_q ? WAIT_RELEASE : IDLE;
            end
            WAIT_RELEASE: begin
                if (!level_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign bus.data_out     = data_q;
    assign bus.data_valid   = (state_q == CAPTURED);
    assign bus.stall        = bus.read_req && (state_q != CAPTURED);
    assign bus.button_level = level_q;

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture with a history-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_input_capture;
    localparam int DC     = 4;
    localparam int M_IDLE = 0;
    localparam int M_WP   = 1;
    localparam int M_CAP  = 2;
    localparam int M_WR   = 3;

    logic clk = 1'b0;
    logic reset;

    input_capture_if bus();

    input_capture #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors  = 0;
    int   checks  = 0;
    int   n_valid = 0;
    int   n_rise  = 0;
    logic prev_lvl = 1'b0;

    // Reference model: raw pin history, synchronized samples since the last level change.
    bit         raw_b[$];
    logic [3:0] raw_s[$];
    bit         sync_run[$];
    int         m_state;
    logic [3:0] m_dout;
    bit         m_level;
    int         m_edge;
    int         m_rise_edge;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_b.delete();
        raw_s.delete();
        sync_run.delete();
        m_state     = M_IDLE;
        m_dout      = 4'h0;
        m_level     = 1'b0;
        m_edge      = 0;
        m_rise_edge = -100;
    endtask

    task automatic model_step();
        bit         sb;
        logic [3:0] ss;
        bit         press;
        bit         all_diff;
        int         n;
        m_edge++;
        n  = raw_b.size();
        // Synchronized value seen at this edge is the raw pin two edges back.
        sb = (n >= 2) ? raw_b[n-2] : 1'b0;
        ss = (n >= 2) ? raw_s[n-2] : 4'h0;
        // The press acts on the FSM two edges after the level rose.
        press = (m_rise_edge == m_edge - 2);
        case (m_state)
            M_IDLE: if (bus.read_req) m_state = M_WP;
            M_WP: begin
                if (!bus.read_req) begin
                    m_state = M_IDLE;
                end else if (press) begin
                    m_dout  = ss;
                    m_state = M_CAP;
                end
            end
            M_CAP:   m_state = m_level ? M_WR : M_IDLE;
            default: if (!m_level) m_state = M_IDLE;
        endcase
        sync_run.push_back(sb);
        all_diff = (sync_run.size() >= DC);
        if (all_diff) begin
            for (int i = sync_run.size() - DC; i < sync_run.size(); i++) begin
                if (sync_run[i] == m_level) all_diff = 1'b0;
            end
        end
        if (all_diff) begin
            m_level = !m_level;
            sync_run.delete();
            if (m_level) m_rise_edge = m_edge;
        end
        raw_b.push_back(bus.button_raw);
        raw_s.push_back(bus.switches_raw);
    endtask

    task automatic compare_step();
        chk("data_valid",   32'(bus.data_valid),   32'(m_state == M_CAP));
        chk("stall",        32'(bus.stall),        32'(bus.read_req && (m_state != M_CAP)));
        chk("data_out",     32'(bus.data_out),     32'(m_dout));
        chk("button_level", 32'(bus.button_level), 32'(m_level));
        if (bus.data_valid) n_valid++;
        if (bus.button_level && !prev_lvl) n_rise++;
        prev_lvl = bus.button_level;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) compare_step();

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int lat;
        int stall_low;
        int v0;
        int r0;
        reset = 1'b1;
        model_reset();
        bus.button_raw   = 1'b0;
        bus.switches_raw = 4'h0;
        bus.read_req     = 1'b0;
        tick(2);
        chk("reset data_out",     32'(bus.data_out),     32'h0);
        chk("reset data_valid",   32'(bus.data_valid),   32'h0);
        chk("reset button_level", 32'(bus.button_level), 32'h0);
        chk("reset stall",        32'(bus.stall),        32'h0);
        reset = 1'b0;
        tick(2);

        // Basic capture and latency, then hold for 100 cycles
        bus.read_req     = 1'b1;
        bus.switches_raw = 4'hA;
        tick(2);
        v0 = n_valid;
        bus.button_raw = 1'b1;
        lat       = 0;
        stall_low = 0;
        while (lat < 30) begin
            @(posedge clk);
            #3;
            lat++;
            if (bus.data_valid) break;
            if (!bus.stall) stall_low++;
        end
        chk("press latency",       32'(lat),          32'd8);
        chk("capture data_out",    32'(bus.data_out), 32'hA);
        chk("capture stall",       32'(bus.stall),    32'h0);
        chk("stall before capture", 32'(stall_low),   32'h0);
        tick(1);
        chk("wait_release stall",  32'(bus.stall),    32'h1);
        tick(100);
        chk("hold single capture", 32'(n_valid - v0), 32'd1);
        bus.button_raw   = 1'b0;
        bus.switches_raw = 4'h3;
        tick(10);
        bus.button_raw = 1'b1;
        tick(12);
        chk("second press capture",  32'(n_valid - v0),  32'd2);
        chk("second press data_out", 32'(bus.data_out), 32'h3);
        bus.button_raw = 1'b0;
        bus.read_req   = 1'b0;
        tick(10);

        // Abort before press, then press while idle and raise read_req while held
        v0 = n_valid;
        bus.read_req = 1'b1;
        tick(3);
        bus.read_req = 1'b0;
        tick(2);
        chk("abort data_out",   32'(bus.data_out), 32'h3);
        bus.switches_raw = 4'hC;
        bus.button_raw   = 1'b1;
        tick(12);
        bus.read_req = 1'b1;
        tick(20);
        chk("idle press no capture", 32'(n_valid - v0),  32'd0);
        chk("idle press data_out",   32'(bus.data_out), 32'h3);
        chk("idle press stall",      32'(bus.stall),    32'h1);
        bus.button_raw = 1'b0;
        tick(10);
        bus.switches_raw = 4'h5;
        bus.button_raw   = 1'b1;
        tick(12);
        chk("re-press capture",  32'(n_valid - v0),  32'd1);
        chk("re-press data_out", 32'(bus.data_out), 32'h5);
        bus.button_raw = 1'b0;
        tick(10);

        // Bounce shorter than the debounce window, then settle high
        v0 = n_valid;
        r0 = n_rise;
        bus.switches_raw = 4'h9;
        for (int i = 0; i < 10; i++) begin
            bus.button_raw = ~bus.button_raw;
            tick(2);
        end
        bus.button_raw = 1'b1;
        tick(15);
        chk("bounce level rises", 32'(n_rise - r0),  32'd1);
        chk("bounce captures",    32'(n_valid - v0), 32'd1);
        chk("bounce data_out",    32'(bus.data_out), 32'h9);
        bus.button_raw = 1'b0;
        tick(10);

        // Reset while in WAIT_PRESS with the debounce count at 2
        bus.switches_raw = 4'h7;
        bus.button_raw   = 1'b1;
        tick(4);
        #1;
        reset = 1'b1;
        #1;
        chk("async reset data_out",     32'(bus.data_out),     32'h0);
        chk("async reset data_valid",   32'(bus.data_valid),   32'h0);
        chk("async reset button_level", 32'(bus.button_level), 32'h0);
        chk("async reset stall",        32'(bus.stall),        32'h1);
        tick(2);
        reset = 1'b0;
        bus.switches_raw = 4'h6;
        v0 = n_valid;
        tick(15);
        chk("post-reset capture",  32'(n_valid - v0),  32'd1);
        chk("post-reset data_out", 32'(bus.data_out), 32'h6);
        bus.button_raw = 1'b0;
        bus.read_req   = 1'b0;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
